// File: rtl/mem_port_sequencer.sv
// Shares one memory port between instruction fetch and load/store, inserting
// read-latency wait states and returning data with a one-cycle completion pulse.
module mem_port_sequencer #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_gnt,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_gnt,
  output logic              data_valid,
  output logic [DATA_W-1:0] data_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [2:0] WAIT_INIT = 3'(READ_LAT - 1);

  state_t     state;
  logic       owner_data;
  logic       last_data;
  logic       we_q;
  logic [2:0] cnt;
  logic       idle;

  assign idle = (state == IDLE);
  assign busy = !idle;

  // Round-robin on a tie: the requester that did not own the port last wins.
  assign fetch_gnt = reset && idle && fetch_req && (!data_req || last_data);
  assign data_gnt  = reset && idle && data_req && (!fetch_req || !last_data);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= IDLE;
      last_data   <= 1'b1;
      owner_data  <= 1'b0;
      we_q        <= 1'b0;
      cnt         <= '0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_wr      <= 1'b0;
      fetch_data  <= '0;
      data_rdata  <= '0;
      fetch_valid <= 1'b0;
      data_valid  <= 1'b0;
    end else begin
      mem_wr      <= 1'b0;
      fetch_valid <= 1'b0;
      data_valid  <= 1'b0;
      case (state)
        IDLE: begin
          if (fetch_gnt || data_gnt) begin
            state      <= ISSUE;
            owner_data <= data_gnt;
            last_data  <= data_gnt;
            we_q       <= data_gnt && data_we;
            mem_wr     <= data_gnt && data_we;
            if (data_gnt) begin
              mem_addr  <= data_addr;
              mem_wdata <= data_wdata;
            end else begin
              mem_addr  <= fetch_addr;
            end
          end
        end
        ISSUE: begin
          cnt <= WAIT_INIT;
          if (we_q) begin
            state      <= RESP;
            data_valid <= 1'b1;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          // Last wait cycle: memory data is valid now, so capture it and respond.
          if (cnt == 3'd0) begin
            state <= RESP;
            if (owner_data) begin
              data_rdata <= mem_rdata;
              data_valid <= 1'b1;
            end else begin
              fetch_data  <= mem_rdata;
              fetch_valid <= 1'b1;
            end
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_sequencer.sv
// Scoreboard bench: a transaction-level model predicts grants, port activity
// and completions; a separate monitor pops and compares each completion.
module tb_mem_port_sequencer;
  parameter int READ_LAT = 2;

  logic        clock, reset;
  logic        fetch_req, fetch_gnt, fetch_valid;
  logic [31:0] fetch_addr, fetch_data;
  logic        data_req, data_we, data_gnt, data_valid;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_wr, busy;

  mem_port_sequencer #(.ADDR_W(32), .DATA_W(32), .READ_LAT(READ_LAT)) dut (
    .clock(clock), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_gnt(data_gnt), .data_valid(data_valid),
    .data_rdata(data_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wr(mem_wr), .mem_rdata(mem_rdata), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    bit          own_data;
    bit          store;
    int          due;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  int          gseq[$];
  logic [31:0] physmem [logic [31:0]];
  logic [31:0] refmem  [logic [31:0]];
  int          n_pass = 0, n_total = 0;
  int          cyc = 0, iss_cyc = -100;
  logic [31:0] iss_addr = 0;
  bit          busy_d = 0, got_f = 0, got_d = 0;
  bit          f_pend = 0, d_pend = 0, rand_mode = 0, hold_both = 0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] phys_read(input logic [31:0] a);
    return physmem.exists(a) ? physmem[a] : memf(a);
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return refmem.exists(a) ? refmem[a] : memf(a);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // One clock cycle: sample grants, advance, act as memory, then drive requesters.
  task automatic tick();
    @(negedge clock);
    got_f = fetch_gnt;
    got_d = data_gnt;
    @(posedge clock);
    #1;
    cyc++;
    if (mem_wr) physmem[mem_addr] = mem_wdata;
    if (busy && !busy_d) begin
      iss_cyc  = cyc;
      iss_addr = mem_addr;
    end
    busy_d    = busy;
    mem_rdata = (cyc == iss_cyc + READ_LAT) ? phys_read(iss_addr) : $urandom;
    if (got_f) begin
      gseq.push_back(0);
      f_pend = 0; fetch_req = 0; fetch_addr = $urandom;
    end
    if (got_d) begin
      gseq.push_back(1);
      d_pend = 0; data_req = 0; data_addr = $urandom;
      data_wdata = $urandom; data_we = 1'($urandom_range(0, 1));
    end
    if (hold_both) begin
      if (got_f) begin f_pend = 1; fetch_req = 1; fetch_addr = 32'($urandom_range(0, 15)) << 2; end
      if (got_d) begin d_pend = 1; data_req = 1; data_addr = 32'($urandom_range(0, 15)) << 2; end
    end
    if (rand_mode) begin
      if (!f_pend && $urandom_range(0, 3) == 0) begin
        f_pend = 1; fetch_req = 1; fetch_addr = 32'($urandom_range(0, 15)) << 2;
      end else if (f_pend && $urandom_range(0, 19) == 0) begin
        f_pend = 0; fetch_req = 0;
      end
      if (!d_pend && $urandom_range(0, 3) == 0) begin
        d_pend = 1; data_req = 1; data_addr = 32'($urandom_range(0, 15)) << 2;
        data_we = 1'($urandom_range(0, 1)); data_wdata = $urandom;
      end else if (d_pend && $urandom_range(0, 19) == 0) begin
        d_pend = 0; data_req = 0;
      end
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((f_pend || d_pend || sb.size() != 0 || busy) && n < 80) begin
      tick();
      n++;
    end
    check("idle_reached", 64'(n < 80), 64'(1));
  endtask

  task automatic wait_grant_fetch();
    int n = 0;
    while (f_pend && n < 40) begin
      tick();
      n++;
    end
    check("fetch_grant_seen", 64'(f_pend), 64'(0));
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_fetch_valid"}, 64'(fetch_valid), 64'(0));
    check({tag, "_data_valid"}, 64'(data_valid), 64'(0));
    check({tag, "_mem_wr"}, 64'(mem_wr), 64'(0));
    check({tag, "_fetch_data"}, 64'(fetch_data), 64'(0));
    check({tag, "_data_rdata"}, 64'(data_rdata), 64'(0));
    check({tag, "_mem_addr"}, 64'(mem_addr), 64'(0));
    check({tag, "_mem_wdata"}, 64'(mem_wdata), 64'(0));
  endtask

  // Reference model: the port is free again 3 cycles after a store grant and
  // READ_LAT+3 cycles after a read grant; ties alternate starting with fetch.
  int          next_free = 0, cur_g = 0;
  bit          last_data = 1, cur_act = 0, cur_we = 0;
  logic [31:0] cur_addr = 0, cur_wdata = 0;

  always @(negedge clock) begin
    bit   idle, efg, edg;
    exp_t e;
    if (!reset) begin
      next_free = cyc + 1;
      last_data = 1;
      cur_act   = 0;
    end else begin
      idle = (cyc >= next_free);
      efg  = idle && fetch_req && (!data_req || last_data);
      edg  = idle && data_req && (!fetch_req || !last_data);
      check("grant", 64'({fetch_gnt, data_gnt}), 64'({efg, edg}));
      check("busy", 64'(busy), 64'(!idle));
      check("mem_wr", 64'(mem_wr), 64'(cur_act && cur_we && cyc == cur_g + 1));
      if (cur_act && cyc > cur_g && cyc < next_free) begin
        check("mem_addr", 64'(mem_addr), 64'(cur_addr));
        if (cur_we) check("mem_wdata", 64'(mem_wdata), 64'(cur_wdata));
      end
      if (efg || edg) begin
        cur_act   = 1;
        cur_g     = cyc;
        cur_we    = edg && data_we;
        cur_addr  = edg ? data_addr : fetch_addr;
        cur_wdata = data_wdata;
        last_data = edg;
        next_free = cyc + (cur_we ? 3 : READ_LAT + 3);
        e.own_data = edg;
        e.store    = cur_we;
        e.due      = next_free - 1;
        e.data     = cur_we ? 32'h0 : ref_read(cur_addr);
        if (cur_we) refmem[cur_addr] = cur_wdata;
        sb.push_back(e);
      end
    end
  end

  // Monitor: every completion pulse is matched against the oldest expectation.
  logic [31:0] ef = 0, ed = 0;

  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      sb.delete();
      ef = 0;
      ed = 0;
    end else if (fetch_valid || data_valid) begin
      check("single_valid", 64'(fetch_valid && data_valid), 64'(0));
      if (sb.size() == 0) begin
        check("unexpected_valid", 64'({fetch_valid, data_valid}), 64'(0));
      end else begin
        e = sb.pop_front();
        check("valid_owner", 64'(data_valid), 64'(e.own_data));
        check("valid_cycle", 64'(cyc), 64'(e.due));
        if (!e.store) begin
          if (e.own_data) ed = e.data;
          else ef = e.data;
        end
        check("fetch_data", 64'(fetch_data), 64'(ef));
        check("data_rdata", 64'(data_rdata), 64'(ed));
      end
    end else if (sb.size() != 0 && cyc > sb[0].due) begin
      check("missing_valid", 64'(0), 64'(1));
      void'(sb.pop_front());
    end
  end

  initial begin
    reset = 0; fetch_req = 0; fetch_addr = 0; data_req = 0; data_we = 0;
    data_addr = 0; data_wdata = 0; mem_rdata = 0;
    repeat (3) tick();
    check_cleared("reset");
    reset = 1;

    // Tie with both requests held: order must be fetch, data, fetch.
    gseq.delete();
    hold_both = 1; data_we = 0;
    f_pend = 1; fetch_req = 1; fetch_addr = 32'h20;
    d_pend = 1; data_req = 1; data_addr = 32'h24;
    for (int n = 0; n < 60 && gseq.size() < 3; n++) tick();
    hold_both = 0;
    f_pend = 0; fetch_req = 0; d_pend = 0; data_req = 0;
    check("tie_grants", 64'(gseq.size() >= 3), 64'(1));
    if (gseq.size() >= 3) begin
      check("tie_order0", 64'(gseq[0]), 64'(0));
      check("tie_order1", 64'(gseq[1]), 64'(1));
      check("tie_order2", 64'(gseq[2]), 64'(0));
    end
    wait_idle();

    // Single fetch from 0x10.
    physmem[32'h10] = 32'h8C22_0004; refmem[32'h10] = 32'h8C22_0004;
    f_pend = 1; fetch_req = 1; fetch_addr = 32'h10;
    wait_idle();
    check("fetch_0x10", 64'(fetch_data), 64'(32'h8C22_0004));

    // Store then load back the same word.
    d_pend = 1; data_req = 1; data_we = 1; data_addr = 32'h40; data_wdata = 32'hDEAD_BEEF;
    wait_idle();
    d_pend = 1; data_req = 1; data_we = 0; data_addr = 32'h40;
    wait_idle();
    check("load_back_0x40", 64'(data_rdata), 64'(32'hDEAD_BEEF));

    // Load requested during a fetch waits for the next idle cycle.
    physmem[32'h80] = 32'h1234_5678; refmem[32'h80] = 32'h1234_5678;
    f_pend = 1; fetch_req = 1; fetch_addr = 32'h10;
    wait_grant_fetch();
    tick();
    d_pend = 1; data_req = 1; data_we = 0; data_addr = 32'h80;
    wait_idle();
    check("busy_load", 64'(data_rdata), 64'(32'h1234_5678));
    check("busy_fetch_kept", 64'(fetch_data), 64'(32'h8C22_0004));

    // Reset during the wait of a fetch drops it; a re-request then completes.
    f_pend = 1; fetch_req = 1; fetch_addr = 32'h10;
    wait_grant_fetch();
    tick();
    reset = 0;
    tick();
    reset = 1;
    check_cleared("midreset");
    repeat (READ_LAT + 3) tick();
    f_pend = 1; fetch_req = 1; fetch_addr = 32'h10;
    wait_idle();
    check("refetch_0x10", 64'(fetch_data), 64'(32'h8C22_0004));

    // Randomized traffic with ties, drops and requests raised while busy.
    rand_mode = 1;
    repeat (800) tick();
    rand_mode = 0;
    wait_idle();
    check("scoreboard_drained", 64'(sb.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
